// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_skid_stage_if
// Brief    : Upstream/downstream handshake bundle for one pipeline stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface pipe_skid_stage_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // The stage itself
    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    // The surrounding pipeline (producer, consumer and flush control)
    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_skid_stage
// Brief    : Generic pipeline stage register with two-entry skid and flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int DATA_W     = 32,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pipe_skid_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;

    // Handshake outputs are registered alongside the state so that no ready
    // path runs combinationally from downstream to upstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (bus.flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            if (FLUSH_ZERO) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_main      <= bus.in_data;
                        r_state     <= BUSY;
                        r_out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= bus.in_data;
                    end else if (w_in_fire) begin
                        r_skid     <= bus.in_data;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_out_fire) begin
                        r_main     <= r_skid;
                        r_state    <= BUSY;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pipe_skid_stage
// Brief    : Scoreboard bench: 64-bit zeroing stage plus a 32-bit keep-payload stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pipe_skid_stage;
    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    int   n_checks;
    int   n_errors;
    bit   mon_en;
    logic [63:0] q[$];

    pipe_skid_stage_if #(.DATA_W(64)) bus_a ();
    pipe_skid_stage_if #(.DATA_W(32)) bus_b ();

    pipe_skid_stage #(.DATA_W(64), .FLUSH_ZERO(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a.slave)
    );

    pipe_skid_stage #(.DATA_W(32), .FLUSH_ZERO(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares stage A against the queue model at each falling edge,
    // then advances the model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            int  sz;
            bit  m_in_fire;
            bit  m_out_fire;
            sz = q.size();
            chk("out_valid", {63'd0, bus_a.out_valid}, {63'd0, sz > 0});
            chk("in_ready",  {63'd0, bus_a.in_ready},  {63'd0, sz < 2});
            if (sz > 0 && bus_a.out_valid)
                chk("out_data", bus_a.out_data, q[0]);
            m_in_fire  = bus_a.in_valid && (sz < 2);
            m_out_fire = bus_a.out_ready && (sz > 0);
            if (!rst_n_a) begin
                q.delete();
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (bus_a.flush) q.delete();
                else if (m_in_fire) q.push_back(bus_a.in_data);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        rst_n_a  = 1'b0;
        rst_n_b  = 1'b0;
        bus_a.flush = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_data = 64'hDEADBEEF; bus_a.out_ready = 1'b1;
        bus_b.flush = 1'b0; bus_b.in_valid = 1'b1; bus_b.in_data = 32'hDEADBEEF; bus_b.out_ready = 1'b0;

        // Reset with input offered: nothing may be captured
        cyc(2);
        chk("rst_a_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("rst_a_in_ready",  {63'd0, bus_a.in_ready},  64'd1);
        chk("rst_a_out_data",  bus_a.out_data,           64'd0);
        chk("rst_b_out_valid", {63'd0, bus_b.out_valid}, 64'd0);
        chk("rst_b_out_data",  {32'd0, bus_b.out_data},  64'd0);
        mon_en  = 1'b1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        bus_b.in_valid = 1'b0;
        cyc(1);
        chk("first_word", bus_a.out_data, 64'hDEADBEEF);

        // Streaming 0x1..0x10 with downstream always ready
        for (int i = 1; i <= 16; i++) begin
            bus_a.in_data = 64'(i);
            cyc(1);
            chk("stream_latency", bus_a.out_data, 64'(i));
        end
        bus_a.in_valid = 1'b0;
        cyc(2);

        // Skid fill: 0xA then 0xB with out_ready dropped in the 0xB cycle
        bus_a.in_valid = 1'b1; bus_a.in_data = 64'hA;
        cyc(1);
        bus_a.in_data = 64'hB; bus_a.out_ready = 1'b0;
        cyc(1);
        bus_a.in_valid = 1'b0; bus_a.in_data = 64'hC;
        chk("full_in_ready", {63'd0, bus_a.in_ready}, 64'd0);
        chk("full_out_data", bus_a.out_data, 64'hA);
        cyc(2);
        chk("full_hold_data", bus_a.out_data, 64'hA);
        bus_a.out_ready = 1'b1;
        cyc(1);
        chk("drain_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
        chk("drain_second",   bus_a.out_data, 64'hB);
        cyc(2);

        // Flush while FULL, with an offered word and downstream ready
        bus_a.in_valid = 1'b1; bus_a.in_data = 64'h5;
        cyc(1);
        bus_a.in_data = 64'h6; bus_a.out_ready = 1'b0;
        cyc(1);
        bus_a.flush = 1'b1; bus_a.in_data = 64'h7; bus_a.out_ready = 1'b1;
        cyc(1);
        bus_a.flush = 1'b0; bus_a.in_valid = 1'b0;
        chk("flush_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("flush_out_data",  bus_a.out_data, 64'd0);
        cyc(2);

        // Reset while FULL drops both entries
        bus_a.in_valid = 1'b1; bus_a.in_data = 64'h11;
        cyc(1);
        bus_a.in_data = 64'h12; bus_a.out_ready = 1'b0;
        cyc(1);
        rst_n_a = 1'b0; bus_a.in_valid = 1'b0;
        cyc(1);
        rst_n_a = 1'b1;
        chk("midrst_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("midrst_in_ready",  {63'd0, bus_a.in_ready},  64'd1);
        chk("midrst_out_data",  bus_a.out_data, 64'd0);
        bus_a.out_ready = 1'b1;
        cyc(1);

        // Stage B: flush keeps payload when zeroing is disabled
        bus_b.in_valid = 1'b1; bus_b.in_data = 32'h5;
        cyc(1);
        bus_b.in_data = 32'h6;
        cyc(1);
        chk("b_full_in_ready", {63'd0, bus_b.in_ready}, 64'd0);
        bus_b.flush = 1'b1; bus_b.in_data = 32'h7;
        cyc(1);
        bus_b.flush = 1'b0; bus_b.in_valid = 1'b0;
        chk("b_flush_out_valid", {63'd0, bus_b.out_valid}, 64'd0);
        chk("b_flush_out_data",  {32'd0, bus_b.out_data}, 64'h5);
        chk("b_flush_in_ready",  {63'd0, bus_b.in_ready}, 64'd1);

        // Stage B: reset wins over flush
        bus_b.in_valid = 1'b1; bus_b.in_data = 32'h9;
        cyc(1);
        bus_b.in_valid = 1'b0;
        chk("b_busy_data", {32'd0, bus_b.out_data}, 64'h9);
        rst_n_b = 1'b0; bus_b.flush = 1'b1;
        cyc(1);
        rst_n_b = 1'b1; bus_b.flush = 1'b0;
        chk("b_rstflush_out_data",  {32'd0, bus_b.out_data}, 64'd0);
        chk("b_rstflush_out_valid", {63'd0, bus_b.out_valid}, 64'd0);

        // Random soak on stage A
        for (int i = 0; i < 10000; i++) begin
            bus_a.in_valid  = ($urandom_range(0, 9) < 7);
            bus_a.out_ready = ($urandom_range(0, 9) < 6);
            bus_a.flush     = ($urandom_range(0, 99) < 2);
            bus_a.in_data   = {$urandom, $urandom};
            cyc(1);
        end
        bus_a.in_valid = 1'b0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b1;
        cyc(3);
        chk("final_drained", {63'd0, bus_a.out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register for the RISC-V core. It replaces the fixed-field, flush-only inter-stage latches with one generic stage: a DATA_W-wide payload, a valid/ready handshake, a two-entry skid buffer, and a synchronous flush. Every stage boundary instantiates it (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage's control and data fields concatenated into `in_data`. Because `in_ready` is registered, a downstream stall reaches the upstream stage one cycle later without a combinational ready path.

## Interface
- `DATA_W`, default 32: payload width in bits (≥1).
- `FLUSH_ZERO`, default 1: 1 = flush also clears both payload registers to 0; 0 = flush clears only valid state and leaves payload unchanged.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage can accept; registered output.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` is valid; registered output.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  head payload; driven directly from the main register.

## Operation
- Handshake events:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
- Storage:
  - main register holds the head entry.
  - skid register holds the second entry.
- FSM states:
  - EMPTY: no entry held.
  - BUSY: main holds the only entry.
  - FULL: main and skid both hold entries.
- Decoded outputs (registered via state):
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL).
- Transitions when `rst_n`=1 and `flush`=0:
  - EMPTY, in_fire: main <= `in_data`; go to BUSY.
  - EMPTY, no in_fire: stay in EMPTY.
  - BUSY, in_fire & out_fire: main <= `in_data`; stay in BUSY.
  - BUSY, in_fire & !out_fire: skid <= `in_data`; go to FULL.
  - BUSY, !in_fire & out_fire: go to EMPTY.
  - BUSY, neither fires: hold.
  - FULL, out_fire: main <= skid; go to BUSY. in_fire cannot occur because `in_ready`=0.
  - FULL, no out_fire: hold; main and skid unchanged.
- Ordering: entries leave strictly in acceptance order. No entry is lost or duplicated.
- Flush (`rst_n`=1, `flush`=1):
  - State goes to EMPTY.
  - Any in_fire in the same cycle is discarded.
  - Any out_fire in the same cycle is still counted as consumed by downstream.
  - With FLUSH_ZERO=1, main and skid are cleared to 0.
- Reset (`rst_n`=0): overrides flush and all handshakes.
  - State goes to EMPTY.
  - main and skid are cleared to 0, regardless of FLUSH_ZERO.
- The stage never drops `out_valid` while a held entry waits. Payload stays stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values, one edge after `rst_n`=0:
  - `out_valid`=0, `in_ready`=1, `out_data`=0.
  - Internal state: EMPTY, skid=0.
- Latency: an entry accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput: 1 entry/cycle when `out_ready` stays high.
- Backpressure: `out_ready` low in cycle N (stage BUSY, in_fire in N) makes `in_ready` low after edge N. The skid register absorbs the one in-flight entry.
- Reset mid-operation in FULL: both entries are lost; outputs show reset values after the edge.
- Flush and `out_ready` together in FULL: after the edge the state is EMPTY, not BUSY.
- `rst_n` and `flush` are sampled only on the rising edge. Neither has any asynchronous effect.

## Test plan
- Reset:
  - Stimulus: drive `rst_n`=0 for 2 cycles with `in_valid`=1, `in_data`=32'hDEADBEEF.
  - Required: `out_valid`=0, `in_ready`=1, `out_data`=0; after release the first accepted word appears one edge later.
- Streaming:
  - Stimulus: `out_ready`=1; send 0x1,0x2,…,0x10 back-to-back.
  - Required: 16 outputs in order on 16 consecutive cycles, each one cycle after its input; `in_ready` never deasserts.
- Skid fill and drain:
  - Stimulus: send 0xA then 0xB; drop `out_ready` in the 0xB cycle.
  - Required: state FULL; `in_ready`=0; `out_data`=0xA held stable.
  - Stimulus: raise `out_ready`.
  - Required: 0xA then 0xB emerge; `in_ready` returns to 1 one edge after the first drain.
- Flush in FULL:
  - Stimulus: stage FULL with 0x5/0x6; assert `flush` with `in_valid`=1, `in_data`=0x7.
  - Required: `out_valid`=0 next cycle; 0x7 is never output; `out_data`=0 (FLUSH_ZERO=1) or 0x5 (FLUSH_ZERO=0).
- Reset overrides flush:
  - Stimulus: `rst_n`=0 and `flush`=1 in the same cycle, FLUSH_ZERO=0, stage BUSY with 0x9.
  - Required: `out_data`=0, `out_valid`=0.
- Random soak:
  - Stimulus: DATA_W=64; random `in_valid`/`out_ready`/`flush`; scoreboard model clears its queue on flush.
  - Required: 10k cycles with zero mismatches, no loss or duplication.
